// File: rtl/buck_ctrl_pkg.sv
// buck_ctrl_pkg: shared gate-controller state encoding and default widths
package buck_ctrl_pkg;
   localparam int CNT_W_DEF = 16;
   localparam int DT_W_DEF  = 8;
   typedef enum logic [2:0] {IDLE, HS_ON, DEAD_HL, LS_ON, DE_OFF, DEAD_LH} state_t;
endpackage

// File: rtl/pwm_period_counter.sv
// pwm_period_counter: period counter with shadowed period/duty/dead-time loaded at cnt==0
module pwm_period_counter
   import buck_ctrl_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int DT_W  = DT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [CNT_W-1:0] period,
   input  logic [CNT_W-1:0] duty,
   input  logic [DT_W-1:0]  dt,
   output logic             cycle_start,
   output logic [CNT_W-1:0] cnt_nxt,
   output logic [CNT_W-1:0] pq_nxt,
   output logic [CNT_W-1:0] dq_nxt,
   output logic [DT_W-1:0]  tq_nxt
);
   logic [CNT_W-1:0] cnt, pq, dq, pq_ld, dq_ld;
   logic [DT_W-1:0]  tq;
   logic             run, wrap, load;
   // The next-cycle view is exported so the FSM can register state aligned with cnt
   always_comb begin
      wrap    = ({1'b0, cnt} + (CNT_W+1)'(1)) >= {1'b0, pq};
      load    = en && (!run || wrap);
      pq_ld   = period < CNT_W'(2) ? CNT_W'(2) : period;
      dq_ld   = duty > pq_ld ? pq_ld : duty;
      cnt_nxt = (!en || load) ? '0 : cnt + CNT_W'(1);
      pq_nxt  = load ? pq_ld : pq;
      dq_nxt  = load ? dq_ld : dq;
      tq_nxt  = load ? dt : tq;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt         <= '0;
         pq          <= CNT_W'(2);
         dq          <= '0;
         tq          <= '0;
         run         <= 1'b0;
         cycle_start <= 1'b0;
      end else begin
         cnt         <= cnt_nxt;
         pq          <= pq_nxt;
         dq          <= dq_nxt;
         tq          <= tq_nxt;
         run         <= en;
         cycle_start <= load;
      end
   end
endmodule

// File: rtl/buck_gate_ctrl.sv
// buck_gate_ctrl: buck high/low-side gate sequencing with dead time and diode emulation
module buck_gate_ctrl
   import buck_ctrl_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int DT_W  = DT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [CNT_W-1:0] period,
   input  logic [CNT_W-1:0] duty,
   input  logic [DT_W-1:0]  dt,
   input  logic             ls_en,
   output logic             hs,
   output logic             ls,
   output logic             cycle_start
);
   state_t           state, state_nxt;
   logic             trip;
   logic [CNT_W-1:0] cnt_nxt, pq_nxt, dq_nxt;
   logic [DT_W-1:0]  tq_nxt;
   logic [CNT_W:0]   c, d, t, p;
   pwm_period_counter #(.CNT_W(CNT_W), .DT_W(DT_W)) u_cnt (
      .clk(clk), .rst(rst), .en(en), .period(period), .duty(duty), .dt(dt),
      .cycle_start(cycle_start), .cnt_nxt(cnt_nxt), .pq_nxt(pq_nxt),
      .dq_nxt(dq_nxt), .tq_nxt(tq_nxt)
   );
   assign trip = state == DE_OFF;
   // State is chosen for the upcoming cnt value so gates change exactly on window edges
   always_comb begin
      c = {1'b0, cnt_nxt};
      d = {1'b0, dq_nxt};
      t = (CNT_W+1)'(tq_nxt);
      p = {1'b0, pq_nxt};
      state_nxt = IDLE;
      if (!en)
         state_nxt = IDLE;
      else if (c < d)
         state_nxt = HS_ON;
      else if (c < d + t)
         state_nxt = DEAD_HL;
      else if (c + t < p)
         state_nxt = ((trip && c != '0) || !ls_en) ? DE_OFF : LS_ON;
      else
         state_nxt = DEAD_LH;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         hs    <= 1'b0;
         ls    <= 1'b0;
      end else begin
         state <= state_nxt;
         hs    <= state_nxt == HS_ON;
         ls    <= state_nxt == LS_ON;
      end
   end
endmodule

// File: doc/buck_gate_ctrl.md
BUCK_GATE_CTRL -- requirements
Module: buck_gate_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, period/duty counter width in bits.
REQ-002 SHALL have parameter DT_W, default 8, dead-time field width in bits.
REQ-003 SHALL have port clk  input  1  sole clock; one clock, all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port en  input  1  converter enable.
REQ-006 SHALL have port period  input  CNT_W  switching period P, in clk cycles.
REQ-007 SHALL have port duty  input  CNT_W  high-side on-time D, in clk cycles.
REQ-008 SHALL have port dt  input  DT_W  dead time T, in clk cycles.
REQ-009 SHALL have port ls_en  input  1  diode-emulation comparator: 1 when i_ind is above the low-side threshold.
REQ-010 SHALL have port hs  output  1  high-side gate drive to the buck stage.
REQ-011 SHALL have port ls  output  1  low-side gate drive to the buck stage.
REQ-012 SHALL have port cycle_start  output  1  one-cycle pulse in the cycle where cnt==0.

Function
REQ-013 SHALL keep a registered counter cnt that steps 0..Pq-1 and wraps to 0 while en=1.
REQ-014 SHALL load shadow registers Pq, Dq, Tq from period, duty and dt only in the cycle cnt becomes 0, i.e. on wrap or on the first enabled cycle; mid-period input changes have no effect.
REQ-015 SHALL clamp values at load time: Pq=max(period,2); Dq=min(duty,Pq).
REQ-016 SHALL drive all outputs directly from registers, with no combinational input-to-output path.
REQ-017 SHALL implement FSM states IDLE, HS_ON, DEAD_HL, LS_ON, DE_OFF, DEAD_LH, with hs=1 only in HS_ON and ls=1 only in LS_ON.
REQ-018 SHALL, in a cycle with cnt=c, be in HS_ON iff c<Dq.
REQ-019 SHALL, for Dq<=c<Dq+Tq, be in DEAD_HL.
REQ-020 SHALL, for Dq+Tq<=c<Pq-Tq, be in LS_ON, or in DE_OFF if diode emulation has tripped this period.
REQ-021 SHALL, for c>=Pq-Tq and c>=Dq+Tq, be in DEAD_LH.
REQ-022 SHALL produce no LS_ON cycle in a period where Dq+Tq>=Pq-Tq.
REQ-023 SHALL produce no HS_ON cycle in a period where Dq==0.
REQ-024 SHALL, in the LS window, trip diode emulation when ls_en is sampled 0: ls goes low in the next cycle and the FSM stays in DE_OFF until DEAD_LH/wrap; a later ls_en=1 does not re-enable ls in that period.
REQ-025 SHALL, when entering the LS window with ls_en=0 already, go to DE_OFF with ls never asserted.
REQ-026 SHALL never assert hs and ls in the same cycle under any input sequence.
REQ-027 SHALL assert cycle_start exactly once per period, in the cycle cnt==0.
REQ-028 SHALL, on en deasserted, go to IDLE the next cycle: hs=ls=cycle_start=0, cnt held at 0.
REQ-029 SHALL, on en reasserted, start a fresh period at cnt=0 with cycle_start=1.
REQ-030 SHALL perform all counter comparisons as unsigned with CNT_W+1-bit intermediates so that Dq+Tq cannot overflow.

Reset
REQ-031 SHALL, in any cycle with rst=1, on the next edge set state=IDLE, cnt=0, hs=0, ls=0, cycle_start=0, Pq=2, Dq=0, Tq=0, diode-emulation trip flag cleared.
REQ-032 SHALL give rst priority over en.
REQ-033 SHALL, on rst asserted mid-period, drop both gates low next cycle.
REQ-034 SHALL, when rst is released with en=1, output cycle_start=1 and cnt=0 in the first cycle.

Structure
REQ-035 SHALL place the FSM state enum and the CNT_W/DT_W defaults in shared package buck_ctrl_pkg.
REQ-036 SHALL implement the period counter and shadow load as sub-module pwm_period_counter; the FSM and diode-emulation logic stay in buck_gate_ctrl.

Verification
REQ-037 SHALL verify: P=100, D=50, T=4, ls_en=1 -> hs for c=0..49; ls for c=54..95; both low for c=50..53 and 96..99.
REQ-038 SHALL verify: same settings, ls_en drops to 0 at c=70 -> ls low from c=71 to period end; ls_en back to 1 at c=80 -> ls stays low; next period is normal.
REQ-039 SHALL verify: duty changed from 50 to 30 at c=20 -> current period hs ends at c=49; next period hs ends at c=29.
REQ-040 SHALL verify: D=0 -> no hs. D=120, P=100 -> hs for all 100 cycles with ls=0. P=100, D=48, T=26 -> ls never asserted.
REQ-041 SHALL verify: en low at c=30 -> hs=ls=0 next cycle; en high again -> cycle_start=1 and hs restarts at cnt=0.
REQ-042 SHALL verify: rst asserted at c=60 while ls=1 -> ls=0 next cycle; assertion hs&ls==0 checked over 10^5 randomized cycles.
